// File: rtl/arith_pkg.sv
// Shared arithmetic package.
// Holds the serial subtractor FSM encoding, the default slice width and the
// helper that sizes the slice index counter.
package arith_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } sub_state_e;

    localparam int unsigned SliceDefault = 8;

    // Width of a counter able to index nslice slices; never narrower than 1 bit.
    function automatic int unsigned idx_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/ripple_borrow_subtractor.sv
// Combinational SLICE-bit subtractor built from a chain of full subtractors.
// Ports:
//   i_a, i_b  : minuend / subtrahend slice
//   i_borrow  : borrow into bit 0
//   o_diff    : i_a - i_b - i_borrow (mod 2^SLICE)
//   o_borrow  : borrow out of the top bit
module ripple_borrow_subtractor #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_borrow,
    output logic [SLICE-1:0] o_diff,
    output logic             o_borrow
);

    logic [SLICE:0] chain;

    assign chain[0] = i_borrow;

    for (genvar i = 0; i < SLICE; i++) begin : g_fs
        assign o_diff[i]    = i_a[i] ^ i_b[i] ^ chain[i];
        // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
        assign chain[i+1]   = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & chain[i]);
    end

    assign o_borrow = chain[SLICE];

endmodule

// File: rtl/serial_subtractor_32.sv
// Multi-cycle subtractor: o_diff = i_a - i_b, one SLICE-bit slice per cycle,
// LSB slice first, with the inter-slice borrow held in a register.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_valid / o_ready     : operand handshake (accepted only in IDLE)
//   i_a, i_b              : minuend, subtrahend
//   o_valid / i_ready     : result handshake (result held until consumed)
//   o_diff                : difference mod 2^WIDTH
//   o_borrow              : unsigned borrow (a < b)
//   o_zero                : o_diff == 0
//   o_overflow            : signed overflow
// WIDTH must be a multiple of SLICE.
module serial_subtractor_32
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = SliceDefault
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_zero,
    output logic             o_overflow
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IW     = idx_width(NSLICE);
    localparam int unsigned MSB    = WIDTH - 1;

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_flag_q, borrow_flag_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] slice_a, slice_b, slice_diff;
    logic             slice_borrow;

    assign slice_a = a_q[idx_q*SLICE +: SLICE];
    assign slice_b = b_q[idx_q*SLICE +: SLICE];

    ripple_borrow_subtractor #(
        .SLICE (SLICE)
    ) u_slice_sub (
        .i_a      (slice_a),
        .i_b      (slice_b),
        .i_borrow (borrow_q),
        .o_diff   (slice_diff),
        .o_borrow (slice_borrow)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        idx_d         = idx_q;
        borrow_d      = borrow_q;
        diff_d        = diff_q;
        borrow_flag_d = borrow_flag_q;
        zero_d        = zero_q;
        ovf_d         = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    a_d      = i_a;
                    b_d      = i_b;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                diff_d[idx_q*SLICE +: SLICE] = slice_diff;
                borrow_d                     = slice_borrow;
                idx_d                        = idx_q + IW'(1);
                if (idx_q == IW'(NSLICE - 1)) begin
                    state_d       = StDone;
                    // Flags are taken from the fully assembled next-state result so
                    // they are final in the same cycle o_valid rises.
                    borrow_flag_d = slice_borrow;
                    zero_d        = ~|diff_d;
                    ovf_d         = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            a_q           <= '0;
            b_q           <= '0;
            idx_q         <= '0;
            borrow_q      <= 1'b0;
            diff_q        <= '0;
            borrow_flag_q <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            idx_q         <= idx_d;
            borrow_q      <= borrow_d;
            diff_q        <= diff_d;
            borrow_flag_q <= borrow_flag_d;
            zero_q        <= zero_d;
            ovf_q         <= ovf_d;
        end
    end

    assign o_ready    = (state_q == StIdle);
    assign o_valid    = (state_q == StDone);
    assign o_diff     = diff_q;
    assign o_borrow   = borrow_flag_q;
    assign o_zero     = zero_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Scoreboard bench for serial_subtractor_32: the driver pushes the expected
// result at each accept, a monitor pops and compares on each result handshake.
module tb_serial_subtractor_32;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_diff;
    logic        o_borrow;
    logic        o_zero;
    logic        o_overflow;

    serial_subtractor_32 dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_diff     (o_diff),
        .o_borrow   (o_borrow),
        .o_zero     (o_zero),
        .o_overflow (o_overflow)
    );

    typedef struct packed {
        logic [31:0] diff;
        logic        br;
        logic        z;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   check_spacing = 1'b0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference using 33-bit arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] d,
                         output logic br, output logic z, output logic ov);
        logic [32:0] u;
        logic [32:0] s;
        u  = {1'b0, a} - {1'b0, b};
        s  = {a[31], a} - {b[31], b};
        d  = u[31:0];
        br = u[32];
        z  = (u[31:0] == 32'd0);
        ov = (s[32] != s[31]);
    endtask

    // Called just after a rising edge; returns just after the accept edge with
    // i_valid still asserted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                         input logic br, input logic z, input logic ov);
        exp_t e;
        bit   got;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        got     = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge i_clk);
            if (o_ready) begin
                e.diff = d;
                e.br   = br;
                e.z    = z;
                e.ov   = ov;
                e.acc  = cyc;
                sb.push_back(e);
                if (check_spacing && last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                got      = 1'b1;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected o_ready within 20 cycles");
        end
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: latency on the rising edge of o_valid, result on each handshake.
    initial begin
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                prev = 1'b0;
            end else begin
                if (o_valid && !prev) begin
                    if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                    else                check("latency", 32'(cyc - sb[0].acc), 32'd5);
                end
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("diff", o_diff, e.diff);
                        check("borrow", 32'(o_borrow), 32'(e.br));
                        check("zero", 32'(o_zero), 32'(e.z));
                        check("overflow", 32'(o_overflow), 32'(e.ov));
                    end
                end
                prev = o_valid && !i_ready;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb, rd, held;
        logic        rbr, rz, rov;
        bit          seen;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_diff", o_diff, 32'd0);
        check("rst_flags", {29'd0, o_borrow, o_zero, o_overflow}, 32'd0);
        @(posedge i_clk);
        #1;

        // Directed vectors (hand-computed)
        issue(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        issue(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        i_valid = 1'b0;

        // Backpressure: DONE held for 3 cycles, a stray i_valid must be ignored
        repeat (8) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        issue(32'hDEAD_BEEF, 32'h0000_BEEF, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        seen    = 1'b0;
        held    = '0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge i_clk);
            if (o_valid) begin
                seen = 1'b1;
                held = o_diff;
            end
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_a     = 32'h0000_0009;
        i_b     = 32'h0000_0001;
        for (int n = 0; n < 3; n++) begin
            @(negedge i_clk);
            check("bp_valid_held", 32'(o_valid), 32'd1);
            check("bp_ready_low", 32'(o_ready), 32'd0);
            check("bp_diff_stable", o_diff, held);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("bp_ready_after", 32'(o_ready), 32'd1);
        check("bp_valid_after", 32'(o_valid), 32'd0);
        @(posedge i_clk);
        #1;

        // Reset two cycles after accept discards the operation
        issue(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        sb.delete();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_diff", o_diff, 32'd0);
        check("midrst_flags", {29'd0, o_borrow, o_zero, o_overflow}, 32'd0);
        @(posedge i_clk);
        #1;
        issue(32'h0000_000A, 32'h0000_0004, 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        repeat (8) @(posedge i_clk);
        #1;

        // Back-to-back random pairs, accepts must be exactly 6 cycles apart
        last_acc      = -1;
        check_spacing = 1'b1;
        for (int k = 0; k < 100; k++) begin
            ra = $urandom;
            rb = (k % 10 == 0) ? ra : $urandom;
            model(ra, rb, rd, rbr, rz, rov);
            issue(ra, rb, rd, rbr, rz, rov);
        end
        i_valid       = 1'b0;
        check_spacing = 1'b0;

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge i_clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_32.md
# serial_subtractor_32

Multi-cycle 32-bit subtractor computing `o_diff = i_a - i_b` one 8-bit slice per cycle, LSB slice first, with the borrow carried between slices in a register. It is the subtraction counterpart of the team's 32-bit carry-select adder. It sits behind a valid/ready handshake on both sides, so datapath blocks can share it where area matters more than latency. It also returns unsigned-borrow, zero and signed-overflow flags for compare logic.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of `SLICE`.
- `SLICE`, 8, bits processed per cycle; `NSLICE = WIDTH/SLICE` (4 at defaults).

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  operands valid.
- `o_ready`  out  1  block can accept operands.
- `i_a`  in  WIDTH  minuend.
- `i_b`  in  WIDTH  subtrahend.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_diff`  out  WIDTH  `i_a - i_b` mod 2^WIDTH.
- `o_borrow`  out  1  final borrow (unsigned a < b).
- `o_zero`  out  1  `o_diff == 0`.
- `o_overflow`  out  1  signed overflow.

## Operation
- FSM states:
  - **IDLE**: `o_ready=1`. On `i_valid`, capture `i_a` and `i_b`, clear the slice index and the borrow, and go to CALC.
  - **CALC**: slice `k = index`. Compute `d_k = a[k] - b[k] - borrow`. Write `d_k` into `o_diff[k*SLICE +: SLICE]` and register the slice borrow-out. Increment the index. After slice `NSLICE-1`, go to DONE.
  - **DONE**: `o_valid=1`. Flags are final. On `i_ready`, go to IDLE.
- Flags:
  - `o_borrow` is the borrow-out of the top slice.
  - `o_zero` is the NOR of all `o_diff` bits.
  - `o_overflow = (a[MSB] != b[MSB]) && (o_diff[MSB] != a[MSB])`.
  - Flags are registered and valid only while `o_valid=1`.
- `i_valid` is ignored outside IDLE. Captured operands are unaffected by input changes after acceptance.
- While `o_valid=1`, `o_diff` and all flags are held stable until the handshake completes.
- Reset, at any time including mid-CALC or in DONE:
  - state goes to IDLE, index and borrow clear, any in-flight operation is discarded;
  - `o_valid=0`, `o_diff=0`, `o_borrow=0`, `o_zero=0`, `o_overflow=0`;
  - `o_ready=1` from the first cycle after reset.

## Timing
- Accept on the edge at cycle T (`i_valid && o_ready`).
- CALC occupies T+1..T+NSLICE: slice 0 at T+1, slice 3 at T+4 (defaults).
- `o_valid` rises at T+NSLICE+1 (T+5).
- If `i_ready=1` at T+5, `o_ready` is 1 at T+6 and the next accept can be at T+6. Minimum issue interval is NSLICE+2 = 6 cycles.
- Backpressure: DONE is held indefinitely while `i_ready=0`.
- `o_ready` is a pure function of state. There is no combinational path from any input to any output.

## Structure
- Shared package `arith_pkg` holds:
  - the FSM state encodings (IDLE/CALC/DONE, 2-bit);
  - the default `SLICE` localparam;
  - the index-width function `$clog2(NSLICE)`.
- Sub-module `ripple_borrow_subtractor`, parameter `SLICE`:
  - ports `i_a[SLICE]`, `i_b[SLICE]`, `i_borrow`, `o_diff[SLICE]`, `o_borrow`;
  - purely combinational, built as a chain of full subtractors, one instance used in CALC.
- The top holds the FSM, operand registers, slice index, borrow register, result register and flag logic.

## Test plan
- `a=0x00000005`, `b=0x00000003` → at T+5: `o_diff=0x00000002`, `borrow=0`, `zero=0`, `overflow=0`.
- `a=0x00000000`, `b=0x00000001` → `o_diff=0xFFFFFFFF`, `borrow=1`, `overflow=0`. A second case checks the cross-slice borrow chain: `a=0x00010000`, `b=0x00000001` → `0x0000FFFF`, `borrow=0`.
- `a=0x80000000`, `b=0x00000001` → `o_diff=0x7FFFFFFF`, `borrow=0`, `overflow=1`. Also `a=0x12345678`, `b=0x12345678` → `o_diff=0`, `zero=1`.
- Backpressure: hold `i_ready=0` for 3 cycles in DONE → `o_valid` and `o_diff` stay stable. A new `i_valid` in that window is ignored (`o_ready=0`). With `i_ready=1`, `o_ready` is 1 on the next cycle.
- Reset at T+2 (mid-CALC) → next cycle `o_valid=0`, `o_ready=1`, all outputs 0. A following op with `a=0x0000000A`, `b=0x00000004` gives `0x00000006` at 5 cycles after accept.
- Back-to-back: 100 random pairs with `i_ready=1` throughout → every result matches `a-b` and the reference flags, with accepts spaced exactly 6 cycles apart.
